// File: rtl/twice_dbg_pkg.sv
// Shared definitions for the twice accelerator debug blocks: the reporter FSM
// states and the layout of the deadlock report word.
package twice_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WATCH  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Count field sits at the bottom of the report word, mask field directly above it.
  localparam int CNT_OFS = 0;

  function automatic int report_width(input int num_axis, input int cnt_w);
    return num_axis + cnt_w;
  endfunction

  function automatic int mask_ofs(input int cnt_w);
    return cnt_w;
  endfunction

endpackage

// File: rtl/twice_hls_deadlock_reporter.sv
// Confirms a persistent HLS deadlock-monitor block indication, records which AXIS
// channels were involved, and hands one report word downstream with a sticky flag.
module twice_hls_deadlock_reporter
  import twice_dbg_pkg::*;
#(
  parameter int NUM_AXIS  = 2,
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 1000
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       block_in,
  input  logic [NUM_AXIS-1:0]                        axis_block_sigs,
  input  logic                                       clear,
  output logic                                       report_valid,
  input  logic                                       report_ready,
  output logic [report_width(NUM_AXIS, CNT_W)-1:0]   report_data,
  output logic                                       deadlock
);

  localparam int RW       = report_width(NUM_AXIS, CNT_W);
  localparam int MASK_OFS = mask_ofs(CNT_W);
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  if (THRESHOLD < 1 || longint'(THRESHOLD) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_threshold
    $error("twice_hls_deadlock_reporter: THRESHOLD out of range 1..2^CNT_W-1");
  end

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_AXIS-1:0] mask;
  logic                pend_clr;

  logic [CNT_W-1:0]    cnt_inc;
  logic [NUM_AXIS-1:0] mask_acc;
  logic [RW-1:0]       report_word;

  // In IDLE the run starts fresh, so the mask is not merged with stale contents.
  always_comb begin
    cnt_inc     = cnt + CNT_W'(1);
    mask_acc    = (state == IDLE) ? axis_block_sigs : (mask | axis_block_sigs);
    report_word = '0;
    report_word[CNT_OFS +: CNT_W]     = THR;
    report_word[MASK_OFS +: NUM_AXIS] = mask_acc;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order inside this block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mask         <= '0;
      pend_clr     <= 1'b0;
      report_valid <= 1'b0;
      report_data  <= '0;
      deadlock     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (block_in) begin
            cnt  <= CNT_W'(1);
            mask <= mask_acc;
            if (THR == CNT_W'(1)) begin
              state        <= REPORT;
              report_valid <= 1'b1;
              deadlock     <= 1'b1;
              report_data  <= report_word;
            end else begin
              state <= WATCH;
            end
          end
        end
        WATCH: begin
          if (clear || !block_in) begin
            state <= IDLE;
            cnt   <= '0;
            mask  <= '0;
          end else begin
            cnt  <= cnt_inc;
            mask <= mask_acc;
            if (cnt_inc == THR) begin
              state        <= REPORT;
              report_valid <= 1'b1;
              deadlock     <= 1'b1;
              report_data  <= report_word;
            end
          end
        end
        REPORT: begin
          // A clear during the stall is remembered and applied at handshake time.
          if (report_ready) begin
            report_valid <= 1'b0;
            if (pend_clr || clear) begin
              state    <= IDLE;
              deadlock <= 1'b0;
              cnt      <= '0;
              mask     <= '0;
              pend_clr <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end else if (clear) begin
            pend_clr <= 1'b1;
          end
        end
        HOLD: begin
          if (clear) begin
            state    <= IDLE;
            deadlock <= 1'b0;
            cnt      <= '0;
            mask     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twice_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter: one instance at THRESHOLD=4, one at THRESHOLD=1.
module tb_twice_hls_deadlock_reporter;

  logic clk = 1'b0;
  logic rst;

  logic        b4, c4, r4, v4, d4;
  logic [1:0]  a4;
  logic [17:0] q4;

  logic        b1, c1, r1, v1, d1;
  logic [1:0]  a1;
  logic [17:0] q1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  twice_hls_deadlock_reporter #(.NUM_AXIS(2), .CNT_W(16), .THRESHOLD(4)) u_t4 (
    .clock(clk), .reset(rst), .block_in(b4), .axis_block_sigs(a4), .clear(c4),
    .report_valid(v4), .report_ready(r4), .report_data(q4), .deadlock(d4)
  );

  twice_hls_deadlock_reporter #(.NUM_AXIS(2), .CNT_W(16), .THRESHOLD(1)) u_t1 (
    .clock(clk), .reset(rst), .block_in(b1), .axis_block_sigs(a1), .clear(c1),
    .report_valid(v1), .report_ready(r1), .report_data(q1), .deadlock(d1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    b4 = 0; c4 = 0; r4 = 0; a4 = 2'b00;
    b1 = 0; c1 = 0; r1 = 0; a1 = 2'b00;
    #12;
    check("reset_v4", v4, 0);
    check("reset_d4", d4, 0);
    check("reset_q4", q4, 0);
    check("reset_v1", v1, 0);
    check("reset_d1", d1, 0);
    rst = 1'b0;
    tick();

    // Run 1: four high samples, mask 01,01,10,10 -> report {11, 4}
    b4 = 1; r4 = 1; a4 = 2'b01;
    tick(); tick();
    a4 = 2'b10;
    tick();
    check("run1_no_early_valid", v4, 0);
    tick();
    b4 = 0; a4 = 2'b00;
    check("run1_valid", v4, 1);
    check("run1_data", q4, 18'h30004);
    check("run1_deadlock", d4, 1);
    tick();
    check("run1_valid_one_cycle", v4, 0);
    check("run1_deadlock_sticky", d4, 1);
    tick(); tick();
    check("run1_deadlock_still", d4, 1);
    c4 = 1;
    tick();
    c4 = 0;
    check("run1_cleared", d4, 0);

    // Run 2: 3 high, 1 low, 3 high -> progress discarded, no report
    b4 = 1; a4 = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    b4 = 0;
    tick();
    b4 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_no_report", v4, 0);
    end
    check("gap_no_deadlock", d4, 0);
    b4 = 0;
    tick();

    // Run 3: stalled report with clear during the stall -> IDLE on handshake
    r4 = 0; b4 = 1; a4 = 2'b10;
    for (int i = 0; i < 4; i++) tick();
    check("stall_valid", v4, 1);
    check("stall_data", q4, 18'h20004);
    b4 = 0; a4 = 2'b01;
    for (int i = 0; i < 5; i++) begin
      c4 = (i == 1);
      tick();
      check("stall_valid_held", v4, 1);
      check("stall_data_held", q4, 18'h20004);
    end
    c4 = 0;
    r4 = 1;
    tick();
    check("stall_hs_valid", v4, 0);
    check("stall_hs_deadlock", d4, 0);

    // Back in IDLE: a fresh run reports after four samples; then stays in HOLD
    b4 = 1; a4 = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    check("idle_restart_not_yet", v4, 0);
    tick();
    check("idle_restart_valid", v4, 1);
    check("idle_restart_data", q4, 18'h30004);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_no_second_report", v4, 0);
    end
    check("hold_deadlock", d4, 1);
    c4 = 1;
    tick();
    c4 = 0;
    check("hold_clear", d4, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rerun_not_yet", v4, 0);
    end
    tick();
    check("rerun_valid", v4, 1);
    check("rerun_data", q4, 18'h30004);
    b4 = 0;
    tick();
    check("rerun_hs", v4, 0);

    // THRESHOLD=1: single pulse reports on the next cycle
    b1 = 1; a1 = 2'b10;
    tick();
    b1 = 0; a1 = 2'b00;
    check("t1_valid", v1, 1);
    check("t1_data", q1, 18'h20001);
    check("t1_deadlock", d1, 1);
    tick();
    check("t1_stall_held", v1, 1);

    // Asynchronous reset mid-report drops outputs before the next edge
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", v1, 0);
    check("async_rst_deadlock", d1, 0);
    check("async_rst_data", q1, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle_valid", v1, 0);
      check("post_rst_idle_deadlock", d1, 0);
    end
    b1 = 1; a1 = 2'b01; r1 = 1;
    tick();
    b1 = 0;
    check("post_rst_report", v1, 1);
    check("post_rst_data", q1, 18'h10001);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/twice_hls_deadlock_reporter.md
Name: twice_hls_deadlock_reporter

Overview:
- Consumer end of the HLS deadlock monitor `block` output, instantiated beside the twice accelerator.
- Confirms that a block indication persists for THRESHOLD consecutive cycles before declaring a deadlock.
- Accumulates which AXIS channels contributed to the block.
- Delivers one report word over a valid/ready handshake and raises a sticky deadlock flag until software clears it.

Parameters:
- NUM_AXIS, 2: number of AXIS block lines observed (matches the monitor's axis_block_sigs width).
- CNT_W, 16: persistence counter width.
- THRESHOLD, 1000: consecutive high samples of block_in required to declare deadlock. Legal range 1..2^CNT_W-1; a compile-time check rejects 0 or values above that range.

Ports:
- clock  in  1  single clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- block_in  in  1  `block` from the deadlock monitor.
- axis_block_sigs  in  NUM_AXIS  per-channel AXIS block lines (same signals the monitor sees).
- clear  in  1  single-cycle software clear of the deadlock condition.
- report_valid  out  1  report word available.
- report_ready  in  1  downstream accepts report.
- report_data  out  NUM_AXIS+CNT_W  {channel_mask[NUM_AXIS-1:0], persist_cnt[CNT_W-1:0]}.
- deadlock  out  1  sticky deadlock flag.

Behaviour:
- Reset values: state=IDLE, cnt=0, mask=0, pend_clr=0, report_valid=0, report_data=0, deadlock=0.
- All outputs are registered; no combinational input-to-output path.
- IDLE:
  - block_in=1: cnt<=1, mask<=axis_block_sigs, go WATCH (or REPORT directly if THRESHOLD==1).
  - Otherwise stay in IDLE.
- WATCH:
  - block_in=1: cnt<=cnt+1, mask<=mask|axis_block_sigs. When cnt+1==THRESHOLD, go REPORT.
  - block_in=0: cnt<=0, mask<=0, go IDLE. A broken run discards all progress.
  - clear=1: same as block_in=0 (abort the run), overriding block_in.
- REPORT entry (same edge):
  - report_valid<=1, deadlock<=1, report_data<={final mask, THRESHOLD}.
  - Latency: block_in high on samples 0..THRESHOLD-1 gives report_valid high in cycle THRESHOLD.
- REPORT:
  - report_data is held stable while report_valid=1 and report_ready=0.
  - block_in and axis_block_sigs are ignored.
  - clear=1 is not applied immediately: it sets pend_clr<=1.
  - Handshake (valid&&ready): report_valid<=0. If pend_clr, or clear in the same cycle: deadlock<=0, cnt<=0, mask<=0, pend_clr<=0, go IDLE. Otherwise go HOLD.
- HOLD:
  - deadlock stays 1 and cnt is frozen. block_in may stay high or fall; no new report is produced.
  - clear=1: deadlock<=0, cnt<=0, mask<=0, go IDLE.
  - A new run may start the cycle after returning to IDLE.
- Counter arithmetic:
  - Unsigned CNT_W bits.
  - It stops at THRESHOLD by construction, so it never wraps and needs no saturation logic.
- Reset mid-operation:
  - Asynchronous reset drops report_valid and deadlock immediately, with no handshake completion.
  - Downstream must treat reset as a report discard.
- clear in IDLE is a no-op.

Decomposition:
- Shared package twice_dbg_pkg holds:
  - the state enum (IDLE, WATCH, REPORT, HOLD);
  - a constant function for report width (NUM_AXIS+CNT_W);
  - field offset constants for the mask and count within report_data.
- The block is a single module. The persistence counter is too small to justify a sub-module.

Test Plan:
- THRESHOLD=4, block_in high 4 cycles, axis_block_sigs=2'b01 then 2'b10, ready=1 -> report_valid high in cycle 4 for 1 cycle, report_data={2'b11,16'd4}, deadlock=1 and stays high.
- THRESHOLD=4, block_in high 3 cycles, low 1 cycle, high 3 cycles -> no report, deadlock stays 0, cnt returns to 0 at the gap.
- Report with ready=0 for 5 cycles -> valid and data stable throughout. clear pulsed in cycle 2 of the stall, then ready=1 -> handshake completes, deadlock=0 next cycle, state IDLE (not HOLD).
- After report accepted, block_in stays high 20 cycles -> no second report. clear pulse -> deadlock=0. Block still high -> new report after 4 more cycles.
- THRESHOLD=1, single-cycle block_in pulse with mask 2'b10 -> report_valid the next cycle, report_data={2'b10,16'd1}.
- Assert reset asynchronously while report_valid=1 and ready=0 -> report_valid and deadlock fall before the next clock edge. After release, block_in=0 -> remains IDLE.
